frame_bram_reader: RTL
======================

Name: frame_bram_reader

Overview:
- Display-side reader for the captured-frame BRAM: fetches the stored 640x400 RGB332 frame and drives 24-bit pixels into the VGA pixel path.
- Places the image at a programmable screen offset and compensates the BRAM read latency.
- Delays sync and blank so they stay aligned with the pixel data.
- Sits between the frame BRAM read port (write side is owned by the capture logic) and the video output mux.

Parameters:
- IMG_W, 640, stored image width in pixels.
- IMG_H, 400, stored image height in lines.
- ADDR_W, 18, BRAM address width.
- BRAM_LATENCY, 2, clock cycles from registered address to valid bram_dout.
- BORDER_COLOR, 24'h000000, pixel value outside the image window or when not active.

Ports:
- clk  in  1  pixel clock (65 MHz domain).
- rst  in  1  synchronous, active-high reset.
- enable  in  1  frame stored and readable; level-sensitive.
- hcount  in  11  current pixel column.
- vcount  in  10  current line.
- hsync  in  1  raw horizontal sync.
- vsync  in  1  raw vertical sync.
- blank  in  1  raw blanking.
- x_off  in  11  window left edge.
- y_off  in  10  window top edge.
- bram_addr  out  ADDR_W  registered read address to the frame BRAM.
- bram_dout  in  8  RGB332 read data {r[2:0],g[2:0],b[1:0]}.
- pixel_out  out  24  RGB888 pixel.
- hsync_out  out  1  hsync delayed by D.
- vsync_out  out  1  vsync delayed by D.
- blank_out  out  1  blank delayed by D.
- active  out  1  high while in ACTIVE state.

Behaviour:
- Pipeline delay D = BRAM_LATENCY+2. The value on hcount/vcount/hsync/vsync/blank at cycle t appears on the outputs at cycle t+D.
- Reset values: bram_addr=0, pixel_out=BORDER_COLOR, all sync/blank delay taps=0, active=0, state=IDLE, row_base=0, latched offsets=0.
- FSM states:
  - IDLE: enable=0. Outputs BORDER_COLOR. Goes to ARMED when enable=1.
  - ARMED: waits for frame start, defined as hcount==0 && vcount==0. At that cycle it latches x_off_q/y_off_q and goes to ACTIVE.
  - ACTIVE: normal readout.
- enable falling in any state: go to IDLE the next cycle. Pixels already in the pipeline are forced to BORDER_COLOR from the next cycle on. There is no partial-frame restart; re-arming waits for the next frame start.
- Offsets are relatched at every frame start while ACTIVE, so a mid-frame change takes effect on the next frame only (no tearing).
- Window: in_win = ACTIVE && hcount in [x_off_q, x_off_q+IMG_W) && vcount in [y_off_q, y_off_q+IMG_H). Comparisons use 12-bit widened sums so offset+size never overflows.
- Row base, updated at hcount==0 only:
  - vcount==y_off_q: row_base<=0.
  - y_off_q<vcount<y_off_q+IMG_H: row_base<=row_base+IMG_W.
  - Otherwise row_base holds.
- Address: bram_addr <= row_base + (hcount - x_off_q) when in_win. Otherwise bram_addr holds its value (no needless toggling). Maximum address is IMG_W*IMG_H-1 = 255999.
- Clipping: a window extending past the visible area simply never shows the clipped pixels. Row addressing stays correct because it is line-based, not a running counter.
- in_win is delayed D-1 cycles alongside the data. Output register:
  - pixel_out = expand(bram_dout) when the delayed in_win=1 and the delayed blank=0; else BORDER_COLOR.
- Expansion: R={r,r,r[2:1]}, G={g,g,g[2:1]}, B={b,b,b,b}.
  - 8'hFF -> 24'hFFFFFF.
  - 8'h00 -> 24'h000000.
  - 8'hE0 -> 24'hFF0000.
- Simultaneous frame start and enable rising: the transition is IDLE->ARMED only. ACTIVE begins at the following frame start.
- Reset mid-frame: the whole pipeline clears in one cycle. The block resumes via IDLE/ARMED.

Test Plan:
- Reset then enable=1, offsets 0, BRAM model returning addr[7:0] -> first ACTIVE frame: pixel for (h=5,v=0) equals expand(8'h05) exactly D cycles later; (h=0,v=1) reads address 640.
- x_off=100, y_off=50 -> (99,50) gives BORDER_COLOR; (100,50) addr 0; (739,449) addr 255999; (740,449) and (100,450) give BORDER_COLOR.
- x_off=900 (window clipped at h=1023) -> line y_off+1 first pixel reads addr 640, i.e. row_base stays correct despite clipping.
- Change x_off mid-frame -> current frame addresses unchanged; new offset applies from the next (0,0).
- enable dropped at (320,200) -> BORDER_COLOR from the next cycle; no reads resume until enable=1 and a full frame start.
- Sync alignment: hsync/vsync/blank pulses on outputs match inputs delayed exactly D=4 with BRAM_LATENCY=2; blank=1 inside the window forces BORDER_COLOR.

Source files
------------

// File: rtl/frame_bram_reader.sv
// Display-side reader for the captured-frame BRAM: places a stored RGB332 image at a
// programmable offset, hides the BRAM read latency, and keeps sync/blank aligned.
module frame_bram_reader #(
  parameter int unsigned IMG_W        = 640,
  parameter int unsigned IMG_H        = 400,
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned BRAM_LATENCY = 2,
  parameter logic [23:0] BORDER_COLOR = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank,
  input  logic [10:0]       x_off,
  input  logic [9:0]        y_off,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [7:0]        bram_dout,
  output logic [23:0]       pixel_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out,
  output logic              active
);

  localparam int unsigned D  = BRAM_LATENCY + 2;
  localparam int unsigned CW = 12;

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  state_t            state, state_nxt;
  logic              latch;
  logic [10:0]       x_off_q, xo;
  logic [9:0]        y_off_q, yo;
  logic [CW-1:0]     h12, v12, xo12, yo12;
  logic              frame_start, in_win;
  logic [ADDR_W-1:0] row_base, row_base_nxt, addr_nxt;
  logic [10:0]       col;
  logic [D-2:0]      win_taps;
  logic [D-1:0]      hs_taps, vs_taps, bl_taps;

  function automatic logic [23:0] expand(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], d[1:0], d[1:0], d[1:0], d[1:0]};
  endfunction

  assign frame_start = (hcount == 11'd0) && (vcount == 10'd0);

  // Next-state logic; offsets are captured at every frame start while armed or active
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    case (state)
      IDLE:    if (enable) state_nxt = ARMED;
      ARMED: begin
        if (!enable) state_nxt = IDLE;
        else if (frame_start) begin
          state_nxt = ACTIVE;
          latch     = 1'b1;
        end
      end
      ACTIVE: begin
        if (!enable) state_nxt = IDLE;
        else if (frame_start) latch = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The frame-start cycle already uses the offsets being latched for the new frame
  always_comb begin
    xo   = latch ? x_off : x_off_q;
    yo   = latch ? y_off : y_off_q;
    h12  = CW'(hcount);
    v12  = CW'(vcount);
    xo12 = CW'(xo);
    yo12 = CW'(yo);
    in_win = (state == ACTIVE) && enable &&
             (h12 >= xo12) && (h12 < xo12 + CW'(IMG_W)) &&
             (v12 >= yo12) && (v12 < yo12 + CW'(IMG_H));
  end

  // Line-based row addressing, so horizontal clipping cannot skew later rows
  always_comb begin
    row_base_nxt = row_base;
    if (hcount == 11'd0) begin
      if (v12 == yo12)
        row_base_nxt = '0;
      else if ((v12 > yo12) && (v12 < yo12 + CW'(IMG_H)))
        row_base_nxt = row_base + ADDR_W'(IMG_W);
    end
    col      = hcount - xo;
    addr_nxt = row_base_nxt + ADDR_W'(col);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      active    <= 1'b0;
      x_off_q   <= '0;
      y_off_q   <= '0;
      row_base  <= '0;
      bram_addr <= '0;
      win_taps  <= '0;
      hs_taps   <= '0;
      vs_taps   <= '0;
      bl_taps   <= '0;
      pixel_out <= BORDER_COLOR;
    end else begin
      state    <= state_nxt;
      active   <= (state_nxt == ACTIVE);
      row_base <= row_base_nxt;
      if (latch) begin
        x_off_q <= x_off;
        y_off_q <= y_off;
      end
      if (in_win) bram_addr <= addr_nxt;
      win_taps <= enable ? {win_taps[D-3:0], in_win} : '0;
      hs_taps  <= {hs_taps[D-2:0], hsync};
      vs_taps  <= {vs_taps[D-2:0], vsync};
      bl_taps  <= {bl_taps[D-2:0], blank};
      // Dropping enable blanks everything already in flight
      pixel_out <= (enable && win_taps[D-2] && !bl_taps[D-2]) ? expand(bram_dout)
                                                              : BORDER_COLOR;
    end
  end

  assign hsync_out = hs_taps[D-1];
  assign vsync_out = vs_taps[D-1];
  assign blank_out = bl_taps[D-1];

endmodule
